// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram sequencer for the processor control unit.
// Emits the FETCH micro-op run, dispatches the opcode through a run-time
// programmable table, then emits that instruction's micro-op run.
// Registered outputs are derived from the next state so they line up with the
// state they describe; illegal is combinational because it depends on ir_in,
// which is only valid during the DECODE cycle itself.
module micro_sequencer #(
  parameter int OPW         = 6,
  parameter int UAW         = 6,
  parameter int LENW        = 4,
  parameter int MAX_LEN     = 8,
  parameter int FETCH_START = 1,
  parameter int FETCH_LEN   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic [OPW-1:0]  ir_in,
  input  logic            z_flag,
  input  logic            cfg_we,
  input  logic [OPW-1:0]  cfg_op,
  input  logic [UAW-1:0]  cfg_start,
  input  logic [LENW-1:0] cfg_len,
  input  logic            cfg_cond,
  output logic [UAW-1:0]  uaddr,
  output logic            uvalid,
  output logic            decode,
  output logic            instr_done,
  output logic            illegal,
  output logic            busy
);

  localparam int DEPTH = 2 ** OPW;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_EXEC   = 2'd3;

  localparam logic [LENW-1:0] FETCH_LAST = LENW'(FETCH_LEN - 1);
  localparam logic [LENW-1:0] MAX_LEN_L  = LENW'(MAX_LEN);
  localparam logic [LENW-1:0] LEN_ONE    = LENW'(1);
  localparam logic [LENW-1:0] LEN_ZERO   = LENW'(0);
  localparam logic [UAW-1:0]  FETCH_BASE = UAW'(FETCH_START);

  // Dispatch table storage
  logic [UAW-1:0]  tab_start_q [DEPTH];
  logic [LENW-1:0] tab_len_q   [DEPTH];
  logic            tab_cond_q  [DEPTH];

  // Sequencer state
  logic [1:0]      state_q, state_d;
  logic [LENW-1:0] step_q, step_d;
  logic [UAW-1:0]  run_base_q, run_base_d;
  logic [LENW-1:0] run_len_q, run_len_d;
  logic            stop_q, stop_d;

  // Registered outputs
  logic [UAW-1:0]  uaddr_q, uaddr_d;
  logic            uvalid_q, uvalid_d;
  logic            decode_q, decode_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  // Combinational helpers
  logic [UAW-1:0]  ent_start_s;
  logic [LENW-1:0] ent_len_s;
  logic            ent_cond_s;
  logic            stop_pend_s;
  logic            illegal_s;
  logic            cfg_ok_s;

  // Table read uses the pre-write contents, so a same-cycle write never
  // affects the dispatch in progress.
  assign ent_start_s = tab_start_q[ir_in];
  assign ent_len_s   = tab_len_q[ir_in];
  assign ent_cond_s  = tab_cond_q[ir_in];

  // A stop arriving this cycle counts together with an earlier one.
  assign stop_pend_s = stop_q | stop;

  // Over-long runs are rejected so no entry can exceed MAX_LEN.
  assign cfg_ok_s = cfg_we && (cfg_len <= MAX_LEN_L);

  // Dispatch table: cleared on reset, written whenever a legal cfg write arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tab_start_q[i] <= '0;
        tab_len_q[i]   <= '0;
        tab_cond_q[i]  <= 1'b0;
      end
    end else if (cfg_ok_s) begin
      tab_start_q[cfg_op] <= cfg_start;
      tab_len_q[cfg_op]   <= cfg_len;
      tab_cond_q[cfg_op]  <= cfg_cond;
    end else begin
      tab_start_q[cfg_op] <= tab_start_q[cfg_op];
    end
  end

  // Next-state logic: run control, dispatch and run stepping
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    run_base_d = run_base_q;
    run_len_d  = run_len_q;
    stop_d     = stop_q;
    illegal_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // stop is ignored while idle; the request register stays clear
        if (start) begin
          state_d = S_FETCH;
          step_d  = LEN_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        stop_d = stop_pend_s;
        if (step_q == FETCH_LAST) begin
          state_d = S_DECODE;
          step_d  = LEN_ZERO;
        end else begin
          step_d = step_q + LEN_ONE;
        end
      end
      S_DECODE: begin
        step_d = LEN_ZERO;
        if (ent_len_s == LEN_ZERO) begin
          // Unprogrammed opcode: trap, and honour any pending stop here
          illegal_s = 1'b1;
          if (stop_pend_s) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = S_FETCH;
            stop_d  = 1'b0;
          end
        end else begin
          stop_d  = stop_pend_s;
          state_d = S_EXEC;
          if (ent_cond_s && z_flag) begin
            // Taken conditional: single micro-op just past the normal run
            run_base_d = ent_start_s + UAW'(ent_len_s);
            run_len_d  = LEN_ONE;
          end else begin
            run_base_d = ent_start_s;
            run_len_d  = ent_len_s;
          end
        end
      end
      S_EXEC: begin
        if (step_q == (run_len_q - LEN_ONE)) begin
          step_d = LEN_ZERO;
          if (stop_pend_s) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = S_FETCH;
            stop_d  = 1'b0;
          end
        end else begin
          stop_d = stop_pend_s;
          step_d = step_q + LEN_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        step_d  = LEN_ZERO;
        stop_d  = 1'b0;
      end
    endcase
  end

  // Output decode of the next state, so registered outputs match the state
  always_comb begin
    uaddr_d  = '0;
    uvalid_d = 1'b0;
    decode_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = (state_d != S_IDLE);
    case (state_d)
      S_FETCH: begin
        uaddr_d  = FETCH_BASE + UAW'(step_d);
        uvalid_d = 1'b1;
      end
      S_DECODE: begin
        decode_d = 1'b1;
      end
      S_EXEC: begin
        uaddr_d  = run_base_d + UAW'(step_d);
        uvalid_d = 1'b1;
        done_d   = (step_d == (run_len_d - LEN_ONE));
      end
      default: begin
        uaddr_d  = '0;
        uvalid_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      run_base_q <= '0;
      run_len_q  <= '0;
      stop_q     <= 1'b0;
      uaddr_q    <= '0;
      uvalid_q   <= 1'b0;
      decode_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      run_base_q <= run_base_d;
      run_len_q  <= run_len_d;
      stop_q     <= stop_d;
      uaddr_q    <= uaddr_d;
      uvalid_q   <= uvalid_d;
      decode_q   <= decode_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign uaddr      = uaddr_q;
  assign uvalid     = uvalid_q;
  assign decode     = decode_q;
  assign instr_done = done_q;
  assign busy       = busy_q;
  assign illegal    = illegal_s;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a queue-based reference model predicts every
// cycle's outputs; table vectors and hand sequences add fixed expectations.
module tb_micro_sequencer;

  logic       clk, rst_n, start, stop, z_flag, cfg_we, cfg_cond;
  logic [5:0] ir_in, cfg_op, cfg_start, uaddr;
  logic [3:0] cfg_len;
  logic       uvalid, decode, instr_done, illegal, busy;

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .ir_in(ir_in),
    .z_flag(z_flag), .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_start(cfg_start),
    .cfg_len(cfg_len), .cfg_cond(cfg_cond), .uaddr(uaddr), .uvalid(uvalid),
    .decode(decode), .instr_done(instr_done), .illegal(illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-cycle plan of expected micro-ops
  typedef struct packed {
    logic [5:0] a;
    logic       v;
    logic       dec;
    logic       done;
  } rec_t;
  rec_t plan[$];
  int   m_start[64];
  int   m_len[64];
  int   m_cond[64];
  bit   m_run, m_stop;

  // Observation helpers
  int   cap[$];
  bit   after_dec, ill_seen, obs_busy;

  typedef struct {
    int op; int st; int ln; int cd; int we; int z;
    int n; int first; int last; int ill;
  } vec_t;
  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int capv(input int i);
    if (i >= 0 && i < cap.size()) return cap[i];
    return -1;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_stop = 1'b0; plan.delete();
    for (int i = 0; i < 64; i++) begin m_start[i] = 0; m_len[i] = 0; m_cond[i] = 0; end
  endtask

  task automatic push_fetch();
    rec_t r;
    for (int i = 0; i < 3; i++) begin
      r = '0; r.a = 6'((1 + i) % 64); r.v = 1'b1; plan.push_back(r);
    end
    r = '0; r.dec = 1'b1; plan.push_back(r);
  endtask

  task automatic push_run(input int base, input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = '0; r.a = 6'((base + i) % 64); r.v = 1'b1; r.done = (i == n - 1);
      plan.push_back(r);
    end
  endtask

  // Advance the model with the inputs present at the clock edge
  task automatic model_adv();
    rec_t r;
    bit   pend;
    int   op;
    op = int'(ir_in);
    if (!m_run) begin
      if (start) begin m_run = 1'b1; push_fetch(); end
    end else begin
      pend = m_stop | stop;
      m_stop = pend;
      r = plan.pop_front();
      if (r.dec) begin
        if (m_len[op] == 0) begin
          if (pend) begin m_run = 1'b0; m_stop = 1'b0; plan.delete(); end
          else push_fetch();
        end else if (m_cond[op] != 0 && z_flag) begin
          push_run(m_start[op] + m_len[op], 1);
        end else begin
          push_run(m_start[op], m_len[op]);
        end
      end else if (r.done) begin
        if (pend) begin m_run = 1'b0; m_stop = 1'b0; plan.delete(); end
        else push_fetch();
      end
    end
    if (cfg_we && int'(cfg_len) <= 8) begin
      m_start[cfg_op] = int'(cfg_start);
      m_len[cfg_op]   = int'(cfg_len);
      m_cond[cfg_op]  = int'(cfg_cond);
    end
  endtask

  // One clock: compare at negedge, advance model at posedge, clear pulses
  task automatic tick();
    rec_t e;
    @(negedge clk);
    e = '0;
    if (m_run && plan.size() > 0) e = plan[0];
    check("uvalid", 32'(uvalid), 32'(e.v));
    check("busy", 32'(busy), 32'(m_run));
    check("decode", 32'(decode), 32'(e.dec));
    check("instr_done", 32'(instr_done), 32'(e.done));
    check("illegal", 32'(illegal), 32'(e.dec && m_len[ir_in] == 0));
    if (e.v) check("uaddr", 32'(uaddr), 32'(e.a));
    if (uvalid && after_dec) cap.push_back(int'(uaddr));
    if (decode) after_dec = 1'b1;
    if (illegal) ill_seen = 1'b1;
    obs_busy = busy;
    @(posedge clk);
    model_adv();
    #1;
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int k;
    if (v.we != 0) begin
      cfg_we = 1'b1; cfg_op = 6'(v.op); cfg_start = 6'(v.st);
      cfg_len = 4'(v.ln); cfg_cond = 1'(v.cd);
      tick();
    end
    ir_in = 6'(v.op); z_flag = 1'(v.z);
    cap.delete(); after_dec = 1'b0; ill_seen = 1'b0;
    start = 1'b1; tick();
    stop = 1'b1; tick();
    k = 0;
    while (obs_busy && k < 30) begin tick(); k++; end
    check({nm, "_runlen"}, 32'(cap.size()), 32'(v.n));
    if (v.n > 0) begin
      check({nm, "_first"}, 32'(capv(0)), 32'(v.first));
      check({nm, "_last"}, 32'(capv(cap.size() - 1)), 32'(v.last));
    end
    check({nm, "_illegal"}, 32'(ill_seen), 32'(v.ill));
    check({nm, "_idle"}, 32'(obs_busy), 32'(0));
  endtask

  initial begin
    int k;
    //        op  st  ln cd we z   n first last ill
    vt[0] = '{4,  4,  4, 0, 1, 0,  4, 4,   7,   0};
    vt[1] = '{52, 52, 2, 1, 1, 0,  2, 52,  53,  0};
    vt[2] = '{52, 52, 2, 1, 0, 1,  1, 54,  54,  0};
    vt[3] = '{9,  20, 9, 0, 1, 0,  0, 0,   0,   1};
    vt[4] = '{5,  62, 3, 0, 1, 0,  3, 62,  0,   0};
    vt[5] = '{7,  10, 8, 1, 1, 1,  1, 18,  18,  0};
    vt[6] = '{3,  5,  1, 0, 1, 1,  1, 5,   5,   0};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; ir_in = '0; z_flag = 1'b0;
    cfg_we = 1'b0; cfg_op = '0; cfg_start = '0; cfg_len = '0; cfg_cond = 1'b0;
    after_dec = 1'b0; ill_seen = 1'b0; obs_busy = 1'b0;
    model_reset();
    #3;
    check("rst_uaddr", 32'(uaddr), 32'(0));
    check("rst_uvalid", 32'(uvalid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(instr_done), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Same-cycle rewrite of op 4 during its own DECODE: old entry runs
    ir_in = 6'd4; z_flag = 1'b0;
    start = 1'b1; tick();
    k = 0;
    while (!(plan.size() > 0 && plan[0].dec) && k < 10) begin tick(); k++; end
    cap.delete(); after_dec = 1'b0;
    cfg_we = 1'b1; cfg_op = 6'd4; cfg_start = 6'd20; cfg_len = 4'd2; cfg_cond = 1'b0;
    tick();
    start = 1'b1;  // ignored while busy
    for (int i = 0; i < 4; i++) tick();
    check("samecyc_old_len", 32'(cap.size()), 32'(4));
    check("samecyc_old_first", 32'(capv(0)), 32'(4));
    check("samecyc_old_last", 32'(capv(3)), 32'(7));
    cap.delete(); after_dec = 1'b0;
    stop = 1'b1; tick();
    k = 0;
    while (obs_busy && k < 30) begin tick(); k++; end
    check("samecyc_new_len", 32'(cap.size()), 32'(2));
    check("samecyc_new_first", 32'(capv(0)), 32'(20));
    check("samecyc_idle", 32'(obs_busy), 32'(0));

    // Asynchronous reset in the middle of an EXEC run
    cfg_we = 1'b1; cfg_op = 6'd4; cfg_start = 6'd4; cfg_len = 4'd4; cfg_cond = 1'b0;
    tick();
    start = 1'b1; tick();
    k = 0;
    while (!(plan.size() > 0 && plan[0].v && !plan[0].dec && plan[0].a == 6'd4) && k < 10) begin
      tick(); k++;
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_uvalid", 32'(uvalid), 32'(0));
    check("arst_busy", 32'(busy), 32'(0));
    check("arst_uaddr", 32'(uaddr), 32'(0));
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    begin
      vec_t rv;
      rv = '{4, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      run_vec(rv, "after_reset");
    end

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      start  = ($urandom_range(0, 3) == 0);
      stop   = ($urandom_range(0, 15) == 0);
      ir_in  = 6'($urandom_range(0, 7));
      z_flag = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        cfg_we = 1'b1; cfg_op = 6'($urandom_range(0, 7)); cfg_start = 6'($urandom);
        cfg_len = 4'($urandom_range(0, 10)); cfg_cond = 1'($urandom_range(0, 1));
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
